counter_en_arb: RTL and testbench
=================================

# counter_en_arb

Round-robin controller that shares one enabled up/down counter (clk/en/cnt style, `cnt` CW bits) between NREQ requesters. Each requester asks for a job of `len` count steps. The block grants one requester at a time, drives the counter's `en` for exactly `len` cycles, and measures progress from the counter's own `cnt` output using modulo-2^CW arithmetic. The counter itself is unchanged; this block sits beside it and owns its enable.

## Interface
- NREQ, 4, number of requesters (2..8)
- CW, 8, counter width; must match the counter instance
- INC_DEC, 1, 1 = counter increments, 0 = counter decrements; must match the counter's inc_dec
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  request per requester; held high until its done pulse
- len  in  NREQ*CW  per-requester step count, slice i = len[i*CW +: CW]; stable while req[i] is high
- cnt  in  CW  current value of the shared counter
- cnt_en  out  1  enable to the shared counter
- gnt  out  NREQ  one-hot grant, all zero when idle
- done  out  NREQ  one-cycle completion pulse to the owner
- busy  out  1  high in RUN or DONE

## Operation
- Reset values: state IDLE, gnt=0, done=0, cnt_en=0, busy=0, rr pointer=0, owner/base/target=0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE
  - If req≠0, select the first set req bit searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - Latch owner, target=len[owner] and base=cnt. cnt is stable here because cnt_en=0.
  - Go to RUN.
- RUN
  - gnt[owner]=1.
  - elapsed = INC_DEC ? (cnt-base) : (base-cnt), truncated to CW bits, so wrap-around is transparent.
  - cnt_en is combinational: (state==RUN) && (elapsed≠target) && req[owner].
  - If elapsed==target, go to DONE.
  - If req[owner]==0 (abort), go to IDLE with ptr=owner+1 mod NREQ and no done pulse.
- DONE
  - gnt=0, done[owner]=1 for exactly one cycle.
  - ptr=owner+1 mod NREQ; go to IDLE.
- len=0: RUN sees elapsed==target immediately. No cnt_en cycle is issued, and the done pulse still occurs.
- A requester whose req is still high in IDLE after its done pulse is treated as a new job. The round-robin pointer gives the other requesters precedence.
- req bits of non-owners have no effect while busy. len changes by the owner during RUN are ignored because target is latched.
- Simultaneous events:
  - Abort and elapsed==target in the same cycle: completion wins, done is pulsed.
  - rst overrides everything.
- Reset mid-RUN: cnt_en=0 and gnt=0 from the next cycle. No done pulse. The counter keeps its value.

## Timing
- With req[i] rising before edge E0: gnt[i] and cnt_en are high from E0 (1-cycle grant latency).
- cnt_en stays high for exactly len cycles, E0..E0+len-1.
- DONE is entered at edge E0+len+1, so done[i] is high in the cycle after E0+len+1.
- Request-to-done latency is len+2 cycles.
- Back-to-back jobs: one IDLE cycle between done and the next grant.
- Counter advances by exactly len (mod 2^CW) per completed job, or by fewer than len on abort.

## Configuration
- `COUNTER_EN_ARB_SVA_EN` defined: compile in concurrent assertions, each failing with $error:
  - gnt is $onehot0.
  - cnt_en implies gnt≠0.
  - cnt_en in cycle N implies cnt changes by exactly ±1 (per INC_DEC) in cycle N+1.
  - !cnt_en implies cnt is stable.
  - done is $onehot0 and is never high two consecutive cycles.
  - Each done[i] is preceded by gnt[i].
  - Cover properties for abort, len=0 and wrap-around.
- Macro undefined: no assertions. Functional behaviour is identical.

## Test plan
- Single job: cnt=0x10, req[0]=1, len0=5 → gnt=0001 next cycle, 5 cnt_en cycles, cnt=0x15, single done[0] pulse 7 cycles after req.
- Contention: all req high at once, len=2,3,1,4, ptr=0 → grants in order 0,1,2,3, each done pulsed once, total cnt advance 10, one idle cycle between jobs.
- Wrap-around: cnt=0xFD, len1=6 → cnt=0x03 at finish, done[1] pulsed. Repeat with INC_DEC=0, cnt=0x02, len=4 → cnt=0xFE.
- Zero length: len2=0, req[2] → no cnt_en cycle, done[2] 2 cycles after req, cnt unchanged.
- Abort: req[3], len3=10, drop req[3] after 3 enables → cnt_en low the same cycle, cnt advanced 3, no done, pending req[0] granted next.
- Reset mid-RUN: assert rst during a len=20 job → all outputs 0 next cycle, ptr=0, no done; after release, req[1] is granted normally.

Source files
------------

// File: rtl/counter_en_arb.sv
// ============================================================================
// Module   : counter_en_arb
// Brief    : Round-robin owner of a shared enabled up/down counter. Grants one
//            requester at a time and drives the counter enable for exactly
//            len[owner] steps. Progress is measured from the counter's own
//            value, modulo 2^CW.
// Options  : COUNTER_EN_ARB_SVA_EN compiles in protocol assertions and covers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_en_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CW      = 8,
  parameter bit          INC_DEC = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   len,
  input  logic [CW-1:0]        cnt,
  output logic                 cnt_en,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam int unsigned     PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0]      c_st_idle  = 2'd0;
  localparam logic [1:0]      c_st_run   = 2'd1;
  localparam logic [1:0]      c_st_done  = 2'd2;
  localparam logic [PW-1:0]   c_last_idx = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] c_bit0     = NREQ'(1);

  logic [1:0]    state_q,  state_d;
  logic [PW-1:0] ptr_q,    ptr_d;
  logic [PW-1:0] owner_q,  owner_d;
  logic [CW-1:0] base_q,   base_d;
  logic [CW-1:0] target_q, target_d;

  logic [CW-1:0] w_len [NREQ];
  logic          w_found;
  logic          w_hi_found;
  logic [PW-1:0] w_hi_sel;
  logic [PW-1:0] w_lo_sel;
  logic [PW-1:0] w_sel;
  logic [CW-1:0] w_elapsed;
  logic          w_at_target;
  logic          w_owner_req;
  logic [PW-1:0] w_next_ptr;

  // Unpack the per-requester step counts.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign w_len[gi] = len[gi*CW +: CW];
  end

  // Round-robin pick: lowest set req at or above ptr, else lowest set req overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_sel = PW'(i);
        if (PW'(i) >= ptr_q) begin
          w_hi_found = 1'b1;
          w_hi_sel   = PW'(i);
        end
      end
    end
    w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
  end

  assign w_found     = |req;
  // Distance travelled since the grant; wrap-around cancels in CW-bit arithmetic.
  assign w_elapsed   = INC_DEC ? (cnt - base_q) : (base_q - cnt);
  assign w_at_target = (w_elapsed == target_q);
  assign w_owner_req = req[owner_q];
  assign w_next_ptr  = (owner_q == c_last_idx) ? '0 : owner_q + PW'(1);

  // Next-state logic for the IDLE -> RUN -> DONE job sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    base_d   = base_q;
    target_d = target_q;
    case (state_q)
      c_st_idle: begin
        if (w_found) begin
          owner_d  = w_sel;
          target_d = w_len[w_sel];
          base_d   = cnt;   // counter is frozen here since cnt_en is low
          state_d  = c_st_run;
        end
      end
      c_st_run: begin
        // Completion takes priority over a simultaneous abort.
        if (w_at_target) begin
          state_d = c_st_done;
        end else if (!w_owner_req) begin
          ptr_d   = w_next_ptr;
          state_d = c_st_idle;
        end
      end
      c_st_done: begin
        ptr_d   = w_next_ptr;
        state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_st_idle;
      ptr_q    <= '0;
      owner_q  <= '0;
      base_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      base_q   <= base_d;
      target_q <= target_d;
    end
  end

  assign gnt    = (state_q == c_st_run)  ? (c_bit0 << owner_q) : '0;
  assign done   = (state_q == c_st_done) ? (c_bit0 << owner_q) : '0;
  assign busy   = (state_q != c_st_idle);
  // Enable drops in the same cycle the target is reached or the owner lets go.
  assign cnt_en = (state_q == c_st_run) && !w_at_target && w_owner_req;

`ifdef COUNTER_EN_ARB_SVA_EN
  localparam logic [CW-1:0] c_step      = INC_DEC ? CW'(1) : {CW{1'b1}};
  localparam logic [CW-1:0] c_wrap_from = INC_DEC ? {CW{1'b1}} : {CW{1'b0}};

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("gnt is not onehot0");
  a_en_has_gnt: assert property (@(posedge clk) disable iff (rst) cnt_en |-> (gnt != '0))
    else $error("cnt_en without grant");
  a_en_steps: assert property (@(posedge clk) disable iff (rst)
      cnt_en |=> (cnt == $past(cnt) + c_step))
    else $error("counter did not step by one after cnt_en");
  a_idle_stable: assert property (@(posedge clk) disable iff (rst) !cnt_en |=> $stable(cnt))
    else $error("counter moved without cnt_en");
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done))
    else $error("done is not onehot0");
  a_done_single: assert property (@(posedge clk) disable iff (rst) (|done) |=> !(|done))
    else $error("done high on consecutive cycles");

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_done_src
    a_done_after_gnt: assert property (@(posedge clk) disable iff (rst)
        done[gi] |-> $past(gnt[gi]))
      else $error("done without preceding grant");
  end

  c_abort: cover property (@(posedge clk) disable iff (rst)
      (state_q == c_st_run) && !w_owner_req && !w_at_target);
  c_len_zero: cover property (@(posedge clk) disable iff (rst)
      (state_q == c_st_idle) && w_found && (w_len[w_sel] == '0));
  c_wrap: cover property (@(posedge clk) disable iff (rst)
      cnt_en && (cnt == c_wrap_from));
`else
  // Assertions are not compiled in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_en_arb.sv
// ============================================================================
// Module   : tb_counter_en_arb
// Brief    : Bench for counter_en_arb with an incrementing and a decrementing
//            instance sharing one stimulus stream, each beside its own counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_en_arb;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*CW-1:0] len = '0;
  logic [CW-1:0]     cnt_i = '0, cnt_d = '0;
  logic              ld = 1'b0;
  logic [CW-1:0]     ld_i = '0, ld_d = '0;
  logic              en_i, en_d, busy_i, busy_d;
  logic [NREQ-1:0]   gnt_i, gnt_d, done_i, done_d;

  int checks = 0;
  int errors = 0;

  // Reference model state: who holds the counter, how many steps remain,
  // who is owed a done pulse, and where the next search starts.
  int            m_owner = -1;
  int            m_left  = 0;
  int            m_who   = -1;
  int            m_ptr   = 0;
  int            m_len   = 0;
  logic [CW-1:0] m_start_i = '0, m_start_d = '0;

  always #5 clk = ~clk;

  counter_en_arb #(.NREQ(NREQ), .CW(CW), .INC_DEC(1'b1)) u_dut_inc (
    .clk(clk), .rst(rst), .req(req), .len(len), .cnt(cnt_i),
    .cnt_en(en_i), .gnt(gnt_i), .done(done_i), .busy(busy_i)
  );

  counter_en_arb #(.NREQ(NREQ), .CW(CW), .INC_DEC(1'b0)) u_dut_dec (
    .clk(clk), .rst(rst), .req(req), .len(len), .cnt(cnt_d),
    .cnt_en(en_d), .gnt(gnt_d), .done(done_d), .busy(busy_d)
  );

  // The shared counters themselves, with a bench-side load.
  always @(posedge clk) begin
    if (ld) begin
      cnt_i <= ld_i;
      cnt_d <= ld_d;
    end else begin
      if (en_i) cnt_i <= cnt_i + 8'd1;
      if (en_d) cnt_d <= cnt_d - 8'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", nm, $time);
  endtask

  // Behavioural model advanced once per clock.
  always @(posedge clk) begin
    int c;
    if (rst) begin
      m_owner = -1;
      m_who   = -1;
      m_ptr   = 0;
    end else if (m_who >= 0) begin
      m_ptr = (m_who + 1) % NREQ;
      m_who = -1;
    end else if (m_owner >= 0) begin
      if (m_left == 0) begin
        m_who   = m_owner;
        m_owner = -1;
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_left--;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (m_owner < 0 && req[c]) begin
          m_owner   = c;
          m_left    = int'(len[c*CW +: CW]);
          m_len     = m_left;
          m_start_i = cnt_i;
          m_start_d = cnt_d;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    logic [31:0]   e_gnt, e_done;
    logic          e_en, e_busy;
    logic [CW-1:0] adv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_gnt  = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      e_done = (m_who >= 0) ? (32'd1 << m_who) : 32'd0;
      e_en   = (m_owner >= 0) && (m_left > 0) && req[m_owner];
      e_busy = (m_owner >= 0) || (m_who >= 0);
      chk("gnt_inc",  32'(gnt_i),  e_gnt);
      chk("gnt_dec",  32'(gnt_d),  e_gnt);
      chk("done_inc", 32'(done_i), e_done);
      chk("done_dec", 32'(done_d), e_done);
      chk("en_inc",   32'(en_i),   32'(e_en));
      chk("en_dec",   32'(en_d),   32'(e_en));
      chk("busy_inc", 32'(busy_i), 32'(e_busy));
      chk("busy_dec", 32'(busy_d), 32'(e_busy));
      if (m_who >= 0) begin
        adv = cnt_i - m_start_i;
        chk("advance_inc", 32'(adv), 32'(m_len));
        adv = m_start_d - cnt_d;
        chk("advance_dec", 32'(adv), 32'(m_len));
      end
    end
  end

  task automatic load(input logic [CW-1:0] vi, input logic [CW-1:0] vd);
    @(posedge clk); #1;
    ld = 1'b1; ld_i = vi; ld_d = vd;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // One job from request to done; reports edges-to-done and enable cycles.
  task automatic run_job(input int i, input int l, output int lat, output int ens);
    bit got;
    got = 1'b0; lat = 0; ens = 0;
    @(posedge clk); #1;
    len[i*CW +: CW] = CW'(l);
    req[i] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) chk("grant_latency", 32'(gnt_i), 32'd1 << i);
      if (en_i) ens++;
      if (done_i[i]) begin got = 1'b1; break; end
    end
    if (!got) timeout("job_done");
    @(posedge clk); #1;
    req[i] = 1'b0;
    @(negedge clk);
    chk("done_single", 32'(done_i), 32'd0);
  endtask

  // Called at a negedge; waits for done[i], then drops req[i].
  task automatic wait_done_drop(input int i, input int bound);
    bit got;
    got = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (done_i[i]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) timeout("wait_done");
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  initial begin
    int lat, ens, nd, ng, gi;
    int g_order[4], g_time[4], d_time[4], d_cnt[4];
    logic [NREQ-1:0] prev_gnt, drop;
    logic [CW-1:0] saved;
    bit got;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",  32'(gnt_i),  32'd0);
    chk("rst_done", 32'(done_i), 32'd0);
    chk("rst_en",   32'(en_i),   32'd0);
    chk("rst_busy", 32'(busy_i), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single job.
    load(8'h10, 8'h10);
    run_job(0, 5, lat, ens);
    chk("single_latency", lat, 32'd7);
    chk("single_enables", ens, 32'd5);
    chk("single_cnt_inc", 32'(cnt_i), 32'h15);
    chk("single_cnt_dec", 32'(cnt_d), 32'h0B);

    // Zero length.
    run_job(2, 0, lat, ens);
    chk("zero_latency", lat, 32'd2);
    chk("zero_enables", ens, 32'd0);
    chk("zero_cnt_inc", 32'(cnt_i), 32'h15);

    // Wrap-around, both directions.
    load(8'hFD, 8'h02);
    run_job(1, 6, lat, ens);
    chk("wrap_cnt_inc", 32'(cnt_i), 32'h03);
    chk("wrap_cnt_dec6", 32'(cnt_d), 32'hFC);
    load(8'hFD, 8'h02);
    run_job(1, 4, lat, ens);
    chk("wrap_cnt_dec", 32'(cnt_d), 32'hFE);
    chk("wrap_cnt_inc4", 32'(cnt_i), 32'h01);

    // Contention from a fresh pointer.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    load(8'h00, 8'h00);
    @(posedge clk); #1;
    len = {8'd4, 8'd1, 8'd3, 8'd2};
    req = 4'b1111;
    ng = 0; nd = 0; prev_gnt = '0; drop = '0;
    for (int k = 0; k < 4; k++) begin g_order[k] = -1; g_time[k] = 0; d_time[k] = 0; d_cnt[k] = 0; end
    for (int c = 0; c < 200 && nd < 4; c++) begin
      @(posedge clk); #1;
      req = req & ~drop;
      drop = '0;
      @(negedge clk);
      if (gnt_i != '0 && prev_gnt == '0 && ng < 4) begin
        gi = 0;
        for (int k = 0; k < NREQ; k++) if (gnt_i[k]) gi = k;
        g_order[ng] = gi; g_time[ng] = c; ng++;
      end
      prev_gnt = gnt_i;
      for (int k = 0; k < NREQ; k++) begin
        if (done_i[k]) begin
          d_cnt[k]++;
          if (nd < 4) d_time[nd] = c;
          nd++;
          drop[k] = 1'b1;
        end
      end
    end
    if (nd < 4) timeout("contention");
    @(posedge clk); #1; req = req & ~drop;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order%0d", k), 32'(g_order[k]), 32'(k));
      chk($sformatf("done_count%0d", k), 32'(d_cnt[k]), 32'd1);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("idle_gap%0d", k), 32'(g_time[k+1] - d_time[k]), 32'd2);
    chk("contention_cnt_inc", 32'(cnt_i), 32'd10);
    chk("contention_cnt_dec", 32'(cnt_d), 32'hF6);

    // Abort after three enables with req[0] pending.
    load(8'h40, 8'h40);
    @(posedge clk); #1;
    len[3*CW +: CW] = 8'd10;
    req[3] = 1'b1;
    ens = 0; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (en_i) ens++;
      if (ens >= 3) begin got = 1'b1; break; end
      @(posedge clk); #1;
      if (!req[0]) begin len[0 +: CW] = 8'd2; req[0] = 1'b1; end
    end
    if (!got) timeout("abort_enables");
    @(posedge clk); #1; req[3] = 1'b0;
    @(negedge clk);
    chk("abort_en_low", 32'(en_i), 32'd0);
    chk("abort_cnt", 32'(cnt_i), 32'h43);
    got = 1'b0; nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_i[3]) nd++;
      if (gnt_i != '0) begin got = 1'b1; break; end
    end
    if (!got) timeout("abort_next_grant");
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_next_gnt", 32'(gnt_i), 32'b0001);
    wait_done_drop(0, 20);

    // Reset in the middle of a long job.
    load(8'h00, 8'h00);
    @(posedge clk); #1;
    len[1*CW +: CW] = 8'd20;
    req[1] = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_gnt",  32'(gnt_i),  32'd0);
    chk("midrst_en",   32'(en_i),   32'd0);
    chk("midrst_busy", 32'(busy_i), 32'd0);
    chk("midrst_done", 32'(done_i), 32'd0);
    saved = cnt_i;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_cnt_hold", 32'(cnt_i), 32'(saved));
    @(negedge clk);
    chk("midrst_regrant", 32'(gnt_i), 32'b0010);
    wait_done_drop(1, 40);

    // Randomized traffic with aborts, re-requests and wrapping counts.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (req[k]) begin
          if (done_i[k]) begin
            if ($urandom_range(3) != 0) req[k] = 1'b0;
          end else if ($urandom_range(63) == 0) begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(3) == 0) begin
          len[k*CW +: CW] = ($urandom_range(7) == 0) ? CW'($urandom_range(59)) : CW'($urandom_range(5));
          req[k] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
